muldiv_ctrl: RTL and testbench

Sequences the shared iterative multiplier and divider units for the MIPS core and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode and starts the correct unit.
- Applies unsigned and sign fix-ups, then writes HI/LO.
- Stalls the pipeline while a result is pending or MFHI/MFLO would read stale HI/LO.
- Sits between the decode/EX stage and the mult/div datapath units.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_fixup.sv | 37 +++
 rtl/muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide controller.
//   - RES_W         : result / operand width (32)
//   - op_t, OP_*    : decode op encodings (MULT..MFLO)
//   - state_t       : controller state encoding
//   - abs_w()       : two's-complement magnitude; abs of the most negative
//                     value wraps to itself and is then read as unsigned
package muldiv_pkg;

  localparam int RES_W = 32;

  typedef logic [2:0] op_t;

  localparam op_t OP_MULT  = 3'd0;
  localparam op_t OP_MULTU = 3'd1;
  localparam op_t OP_DIV   = 3'd2;
  localparam op_t OP_DIVU  = 3'd3;
  localparam op_t OP_MTHI  = 3'd4;
  localparam op_t OP_MTLO  = 3'd5;
  localparam op_t OP_MFHI  = 3'd6;
  localparam op_t OP_MFLO  = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MSTART = 3'd1,
    MARM   = 3'd2,
    MWAIT  = 3'd3,
    DSTART = 3'd4,
    DARM   = 3'd5,
    DWAIT  = 3'd6,
    FIX    = 3'd7
  } state_t;

  function automatic logic [RES_W-1:0] abs_w(input logic [RES_W-1:0] v);
    return v[RES_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// muldiv_fixup: combinational result correction applied in the FIX state.
//   op             : latched operation (MULT/MULTU/DIV/DIVU)
//   a, b           : original (uncorrected) operands
//   raw_hi, raw_lo : unit result; product hi/lo, or remainder/quotient
//   fix_hi, fix_lo : corrected values to write into HI/LO
// The multiplier is signed only, so MULTU recovers the unsigned high word
// by adding back the operand that the other operand's sign bit subtracted.
// The divider is unsigned only, so DIV restores signs on quotient and
// remainder (remainder follows the dividend).
module muldiv_fixup
  import muldiv_pkg::*;
(
  input  op_t              op,
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic [RES_W-1:0] raw_hi,
  input  logic [RES_W-1:0] raw_lo,
  output logic [RES_W-1:0] fix_hi,
  output logic [RES_W-1:0] fix_lo
);

  always_comb begin
    fix_hi = raw_hi;
    fix_lo = raw_lo;
    case (op)
      OP_MULTU: begin
        fix_hi = raw_hi + (a[RES_W-1] ? b : '0) + (b[RES_W-1] ? a : '0);
      end
      OP_DIV: begin
        if (a[RES_W-1] ^ b[RES_W-1]) fix_lo = -raw_lo;
        if (a[RES_W-1])              fix_hi = -raw_hi;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared iterative multiplier/divider and owns
// the architectural HI/LO registers.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : (MULDIV_FLUSH_EN only) abort the running op
//   op_valid/op       : op from decode; op_ready accepts, stall holds pipe
//   rs_val, rt_val    : operands / MTHI-MTLO source
//   rd_val            : HI or LO for an accepted MFHI/MFLO
//   mul_*             : start pulse, operands, done level and product
//   div_*             : start pulse, operands, done level and q/r
//   unit_rst          : one-cycle reset to both units on abort
//   busy, err         : not idle; sticky timeout flag
//   hi, lo            : architectural HI/LO
// Optional feature macro: MULDIV_FLUSH_EN adds the flush input.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int               TIMEOUT    = 64,
  parameter logic [RES_W-1:0] DIV_ZERO_Q = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MULDIV_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             op_valid,
  input  op_t              op,
  input  logic [RES_W-1:0] rs_val,
  input  logic [RES_W-1:0] rt_val,
  output logic             op_ready,
  output logic             stall,
  output logic [RES_W-1:0] rd_val,
  output logic             mul_start,
  output logic [RES_W-1:0] mul_a,
  output logic [RES_W-1:0] mul_b,
  input  logic             mul_end,
  input  logic [RES_W-1:0] mul_hi,
  input  logic [RES_W-1:0] mul_lo,
  output logic             div_start,
  output logic [RES_W-1:0] div_a,
  output logic [RES_W-1:0] div_b,
  input  logic             div_end,
  input  logic [RES_W-1:0] div_q,
  input  logic [RES_W-1:0] div_r,
  output logic             unit_rst,
  output logic             busy,
  output logic             err,
  output logic [RES_W-1:0] hi,
  output logic [RES_W-1:0] lo
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  op_t              op_reg;
  logic [RES_W-1:0] a_reg, b_reg;
  logic [RES_W-1:0] raw_hi_reg, raw_lo_reg;
  logic [RES_W-1:0] hi_reg, lo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  logic             flush_i;
  logic             accept;
  logic             cnt_last;
  logic             timeout;
  logic             cap_mul, cap_div, fix_we;
  logic [RES_W-1:0] fix_hi, fix_lo;

`ifdef MULDIV_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign op_ready = (state_reg == IDLE) && !flush_i;
  assign accept   = op_valid && op_ready;
  assign stall    = op_valid && !op_ready;
  assign busy     = (state_reg != IDLE);
  assign err      = err_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign cnt_last = (cnt_reg == CNT_LAST);

  // Operands come straight from the latched registers, so they stay stable
  // for the whole operation.
  assign mul_a = a_reg;
  assign mul_b = b_reg;
  assign div_a = (op_reg == OP_DIV) ? abs_w(a_reg) : a_reg;
  assign div_b = (op_reg == OP_DIV) ? abs_w(b_reg) : b_reg;

  always_comb begin
    rd_val = '0;
    if (accept && op == OP_MFHI) rd_val = hi_reg;
    if (accept && op == OP_MFLO) rd_val = lo_reg;
  end

  always_comb begin
    state_next = state_reg;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    unit_rst   = 1'b0;
    timeout    = 1'b0;
    cap_mul    = 1'b0;
    cap_div    = 1'b0;
    fix_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: state_next = MSTART;
            // Divide-by-zero completes from IDLE without touching the unit.
            OP_DIV, OP_DIVU:   if (rt_val != '0) state_next = DSTART;
            default: ;
          endcase
        end
      end
      // Done levels seen during a START cycle belong to the previous op.
      MSTART: begin
        mul_start  = 1'b1;
        state_next = MARM;
      end
      MARM: begin
        if (!mul_end)      state_next = MWAIT;
        else if (cnt_last) timeout    = 1'b1;
      end
      MWAIT: begin
        if (mul_end) begin
          cap_mul    = 1'b1;
          state_next = FIX;
        end else if (cnt_last) begin
          timeout = 1'b1;
        end
      end
      DSTART: begin
        div_start  = 1'b1;
        state_next = DARM;
      end
      DARM: begin
        if (!div_end)      state_next = DWAIT;
        else if (cnt_last) timeout    = 1'b1;
      end
      DWAIT: begin
        if (div_end) begin
          cap_div    = 1'b1;
          state_next = FIX;
        end else if (cnt_last) begin
          timeout = 1'b1;
        end
      end
      FIX: begin
        fix_we     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (timeout) begin
      unit_rst   = 1'b1;
      state_next = IDLE;
    end

    // A flush anywhere outside IDLE (FIX included) drops the result.
    if (flush_i && state_reg != IDLE) begin
      unit_rst   = 1'b1;
      state_next = IDLE;
      cap_mul    = 1'b0;
      cap_div    = 1'b0;
      fix_we     = 1'b0;
      timeout    = 1'b0;
    end
  end

  muldiv_fixup u_fixup (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .raw_hi (raw_hi_reg),
    .raw_lo (raw_lo_reg),
    .fix_hi (fix_hi),
    .fix_lo (fix_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= OP_MULT;
      a_reg      <= '0;
      b_reg      <= '0;
      raw_hi_reg <= '0;
      raw_lo_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        op_reg <= op;
        a_reg  <= rs_val;
        b_reg  <= rt_val;
        if (op == OP_MTHI) hi_reg <= rs_val;
        if (op == OP_MTLO) lo_reg <= rs_val;
        if ((op == OP_DIV || op == OP_DIVU) && rt_val == '0) begin
          lo_reg <= DIV_ZERO_Q;
          hi_reg <= rs_val;
        end
      end

      // Timeout counter covers the ARM and WAIT states together.
      if (state_reg == MSTART || state_reg == DSTART) cnt_reg <= '0;
      else if (state_reg == MARM || state_reg == MWAIT ||
               state_reg == DARM || state_reg == DWAIT) cnt_reg <= cnt_reg + 1'b1;

      if (cap_mul) begin
        raw_hi_reg <= mul_hi;
        raw_lo_reg <= mul_lo;
      end
      if (cap_div) begin
        raw_hi_reg <= div_r;
        raw_lo_reg <= div_q;
      end

      if (fix_we) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end

      if (timeout) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl. Behavioural unit
// models stand in for the iterative multiplier/divider; expected HI/LO come
// from plain 64-bit arithmetic on the original operands.
module tb_muldiv_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
`ifdef MULDIV_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        op_ready, stall, mul_start, div_start, unit_rst, busy, err;
  logic [31:0] rd_val, mul_a, mul_b, div_a, div_b, hi, lo;
  logic        mul_end, div_end;
  logic [31:0] mul_hi, mul_lo, div_q, div_r;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .DIV_ZERO_Q(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst),
`ifdef MULDIV_FLUSH_EN
    .flush(flush),
`endif
    .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .op_ready(op_ready), .stall(stall), .rd_val(rd_val),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_end(mul_end), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_end(div_end), .div_q(div_q), .div_r(div_r),
    .unit_rst(unit_rst), .busy(busy), .err(err), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- unit models ----------------
  // phase 0 idle, 1 dropping the old done level, 2 computing
  bit          mul_hang = 0, div_hang = 0;
  int          force_drop = -1;
  int          mphase, mdrop, mlat, dphase, ddrop, dlat;
  logic [63:0] mres;
  logic [31:0] dres_q, dres_r;
  logic [31:0] div_a_seen, div_b_seen;
  int          div_start_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_end <= 1'b0; mul_hi <= '0; mul_lo <= '0;
      mphase <= 0; mdrop <= 0; mlat <= 0; mres <= '0;
    end else if (unit_rst) begin
      mul_end <= 1'b0; mphase <= 0;
    end else if (mul_start) begin
      mres   <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
      mdrop  <= (force_drop >= 0) ? force_drop : int'($urandom_range(0, 2));
      mlat   <= int'($urandom_range(0, 5));
      mphase <= 1;
    end else if (mphase == 1) begin
      if (mdrop == 0) begin mul_end <= 1'b0; mphase <= 2; end
      else mdrop <= mdrop - 1;
    end else if (mphase == 2 && !mul_hang) begin
      if (mlat == 0) begin
        mul_end <= 1'b1; mul_hi <= mres[63:32]; mul_lo <= mres[31:0]; mphase <= 0;
      end else mlat <= mlat - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_end <= 1'b0; div_q <= '0; div_r <= '0;
      dphase <= 0; ddrop <= 0; dlat <= 0; dres_q <= '0; dres_r <= '0;
      div_a_seen <= '0; div_b_seen <= '0; div_start_cnt <= 0;
    end else if (unit_rst) begin
      div_end <= 1'b0; dphase <= 0;
    end else if (div_start) begin
      dres_q <= (div_b == 0) ? 32'hFFFFFFFF : div_a / div_b;
      dres_r <= (div_b == 0) ? div_a : div_a % div_b;
      div_a_seen <= div_a; div_b_seen <= div_b;
      div_start_cnt <= div_start_cnt + 1;
      ddrop  <= (force_drop >= 0) ? force_drop : int'($urandom_range(0, 2));
      dlat   <= int'($urandom_range(0, 5));
      dphase <= 1;
    end else if (dphase == 1) begin
      if (ddrop == 0) begin div_end <= 1'b0; dphase <= 2; end
      else ddrop <= ddrop - 1;
    end else if (dphase == 2 && !div_hang) begin
      if (dlat == 0) begin
        div_end <= 1'b1; div_q <= dres_q; div_r <= dres_r; dphase <= 0;
      end else dlat <= dlat - 1;
    end
  end

  // ---------------- reference model ----------------
  task automatic ref_exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin pr = 64'(sa * sb); exp_hi = pr[63:32]; exp_lo = pr[31:0]; end
      3'd1: begin pr = {32'b0, a} * {32'b0, b}; exp_hi = pr[63:32]; exp_lo = pr[31:0]; end
      3'd2: begin
        if (b == 0) begin exp_hi = a; exp_lo = 32'hFFFFFFFF; end
        else begin q = sa / sb; r = sa % sb; exp_lo = 32'(q); exp_hi = 32'(r); end
      end
      3'd3: begin
        if (b == 0) begin exp_hi = a; exp_lo = 32'hFFFFFFFF; end
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rdv, output int waited, output bit stall_ok);
    bit ok;
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    ok = 0; waited = 0; stall_ok = 1; rdv = '0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (op_ready === 1'b1) begin rdv = rd_val; ok = 1; break; end
      if (stall !== 1'b1) stall_ok = 0;
      waited++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_bound: op=%0d not accepted, op_ready=%b required 1", o, op_ready);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_bound: busy=%b required 0 within 300 cycles", busy);
    end
  endtask

  // issue + reference update + wait for completion; comparisons stay in tests
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rdv);
    int w; bit s, ok;
    issue(o, a, b, rdv, w, s);
    ref_exec(o, a, b);
    wait_idle(ok);
    $display("txn op=%0d a=%h b=%h rd=%h -> hi=%h lo=%h (exp %h %h)",
             o, a, b, rdv, hi, lo, exp_hi, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL reset_busy_err: busy=%b err=%b required 0/0", busy, err); end
    checks++; if (mul_start !== 1'b0 || div_start !== 1'b0 || unit_rst !== 1'b0) begin errors++;
      $display("FAIL reset_pulses: mul_start=%b div_start=%b unit_rst=%b required 0", mul_start, div_start, unit_rst); end
    checks++; if (rd_val !== 32'h0) begin errors++;
      $display("FAIL reset_rd_val: rd_val=%h required 0", rd_val); end
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++;
      $display("FAIL idle_ready: op_ready=%b required 1", op_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] rdv;
    int          dcnt;
    bit          ok;
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, rdv);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin errors++;
      $display("FAIL mult_neg: hi=%h lo=%h required FFFFFFFF/FFFFFFEB", hi, lo); end
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, rdv);
    checks++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin errors++;
      $display("FAIL multu_fix: hi=%h lo=%h required 00000001/FFFFFFFE", hi, lo); end
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, rdv);
    checks++; if (div_a_seen !== 32'd7 || div_b_seen !== 32'd2) begin errors++;
      $display("FAIL div_operands: div_a=%h div_b=%h required 7/2", div_a_seen, div_b_seen); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++;
      $display("FAIL div_sign: hi=%h lo=%h required FFFFFFFF/FFFFFFFD", hi, lo); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, rdv);
    checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin errors++;
      $display("FAIL div_overflow: hi=%h lo=%h required 00000000/80000000", hi, lo); end
    dcnt = div_start_cnt;
    issue_divzero: begin
      int w; bit s;
      issue(3'd3, 32'd5, 32'd0, rdv, w, s);
      ref_exec(3'd3, 32'd5, 32'd0);
      // accept edge has passed: result must already be visible
      checks++; if (hi !== 32'd5 || lo !== 32'hFFFFFFFF || busy !== 1'b0) begin errors++;
        $display("FAIL divu_zero: hi=%h lo=%h busy=%b required 5/FFFFFFFF/0", hi, lo, busy); end
      wait_idle(ok);
      repeat (3) @(negedge clk);
      checks++; if (div_start_cnt !== dcnt) begin errors++;
        $display("FAIL divzero_nostart: div_start pulses=%0d required %0d", div_start_cnt, dcnt); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, rdv, want;
    for (int n = 0; n < 80; n++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : pick();
      want = (o == 3'd6) ? exp_hi : exp_lo;
      run_op(o, a, b, rdv);
      if (o == 3'd6 || o == 3'd7) begin
        checks++; if (rdv !== want) begin errors++;
          $display("FAIL rand_rd_val[%0d]: op=%0d rd_val=%h required %h", n, o, rdv, want); end
      end
      checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
        $display("FAIL rand_hilo[%0d]: op=%0d a=%h b=%h hi=%h lo=%h required %h/%h",
                 n, o, a, b, hi, lo, exp_hi, exp_lo); end
    end
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL rand_err: err=%b required 0", err); end
  endtask

  task automatic test_mf_during_mult();
    logic [31:0] a, b, rdv;
    int w; bit s, ok;
    a = $urandom; b = $urandom;
    issue(3'd0, a, b, rdv, w, s);
    ref_exec(3'd0, a, b);
    issue(3'd7, 32'h0, 32'h0, rdv, w, s);
    $display("txn op=7 during MULT a=%h b=%h waited=%0d rd=%h", a, b, w, rdv);
    checks++; if (w < 4) begin errors++;
      $display("FAIL mf_stall_len: waited %0d cycles required >= 4", w); end
    checks++; if (s !== 1'b1) begin errors++;
      $display("FAIL mf_stall_level: stall dropped while not ready, required 1"); end
    checks++; if (rdv !== exp_lo) begin errors++;
      $display("FAIL mf_rd_val: rd_val=%h required %h", rdv, exp_lo); end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rdv;
    force_drop = 2;   // previous done level lingers two extra cycles
    run_op(3'd0, 32'd1234, 32'd5678, rdv);
    run_op(3'd0, 32'h00010000, 32'h00030000, rdv);
    checks++; if (hi !== 32'h3 || lo !== 32'h0) begin errors++;
      $display("FAIL b2b_mult: hi=%h lo=%h required 00000003/00000000", hi, lo); end
    run_op(3'd3, 32'd100, 32'd7, rdv);
    run_op(3'd3, 32'd1000, 32'd9, rdv);
    checks++; if (hi !== 32'd1 || lo !== 32'd111) begin errors++;
      $display("FAIL b2b_divu: hi=%h lo=%h required 00000001/0000006F", hi, lo); end
    force_drop = -1;
  endtask

  task automatic test_timeout();
    logic [31:0] rdv;
    int          cyc, w;
    bit          s, seen;
    mul_hang = 1;
    issue(3'd0, 32'd3, 32'd3, rdv, w, s);
    cyc = 0; seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (unit_rst === 1'b1) begin seen = 1; break; end
    end
    $display("txn MULT hang: unit_rst after %0d cycles", cyc);
    checks++; if (!seen || cyc < TIMEOUT || cyc > TIMEOUT + 2) begin errors++;
      $display("FAIL timeout_pulse: seen=%0b after %0d cycles required %0d..%0d", seen, cyc, TIMEOUT, TIMEOUT + 2); end
    @(negedge clk);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL timeout_flags: err=%b busy=%b required 1/0", err, busy); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL timeout_hilo: hi=%h lo=%h required %h/%h", hi, lo, exp_hi, exp_lo); end
    checks++; if (unit_rst !== 1'b0) begin errors++;
      $display("FAIL timeout_one_pulse: unit_rst=%b required 0", unit_rst); end
    mul_hang = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] rdv;
    int w; bit s;
    div_hang = 1;
    issue(3'd2, 32'd100, 32'd7, rdv, w, s);
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL arst_busy_before: busy=%b required 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || err !== 1'b0) begin errors++;
      $display("FAIL arst_immediate: busy=%b hi=%h lo=%h err=%b required 0/0/0/0", busy, hi, lo, err); end
    @(negedge clk);
    rst = 1'b0; div_hang = 0;
    exp_hi = '0; exp_lo = '0;
    run_op(3'd3, 32'd17, 32'd5, rdv);
    checks++; if (hi !== 32'd2 || lo !== 32'd3) begin errors++;
      $display("FAIL arst_recover: hi=%h lo=%h required 2/3", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mf_during_mult();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
